// File: rtl/multitap_word_entry.sv
// multitap_word_entry: phone-keypad multi-tap letter entry with a small word
// buffer that is streamed out oldest-first on submit.
module multitap_word_entry #(
    parameter int TIMEOUT_CYCLES = 12000000,
    parameter int WORD_DEPTH     = 8,
    localparam int CW            = $clog2(WORD_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          strobe,
    input  logic [7:0]    cur_key,
    output logic [7:0]    pending,
    output logic          letter_valid,
    output logic [7:0]    letter,
    output logic          overflow,
    output logic [CW-1:0] count,
    output logic          word_valid,
    output logic [7:0]    word_data,
    output logic          word_last,
    input  logic          word_ready,
    output logic          game_end
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = $clog2(WORD_DEPTH);
    localparam logic [3:0] K_END  = 4'd11;
    localparam logic [3:0] K_SUBL = 4'd12;
    localparam logic [3:0] K_CLR  = 4'd13;
    localparam logic [3:0] K_SUBW = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_TAP, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [3:0]      key_q, key_d;
    logic [1:0]      tap_q, tap_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [7:0]      letter_q, letter_d;
    logic            letter_valid_q, letter_valid_d;
    logic            overflow_q, overflow_d;
    logic            game_end_q, game_end_d;
    logic [7:0]      mem_q [WORD_DEPTH];

    logic [1:0]      ri, ci;
    logic [3:0]      code;
    logic            key_ok, is_letter, commit, wr_en, last;
    logic [1:0]      tap_max;
    logic [7:0]      cand;

    function automatic logic onehot4(input logic [3:0] x);
        return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
    endfunction

    // Base letter of a key code {row, col}; zero for non-letter keys.
    function automatic logic [7:0] key_base(input logic [3:0] k);
        case (k)
            4'd1:    return 8'h41;
            4'd2:    return 8'h44;
            4'd4:    return 8'h47;
            4'd5:    return 8'h4A;
            4'd6:    return 8'h4D;
            4'd8:    return 8'h50;
            4'd9:    return 8'h54;
            4'd10:   return 8'h57;
            default: return 8'h00;
        endcase
    endfunction

    assign ri        = cur_key[7] ? 2'd0 : cur_key[6] ? 2'd1 : cur_key[5] ? 2'd2 : 2'd3;
    assign ci        = cur_key[3] ? 2'd0 : cur_key[2] ? 2'd1 : cur_key[1] ? 2'd2 : 2'd3;
    assign code      = {ri, ci};
    assign key_ok    = strobe && onehot4(cur_key[7:4]) && onehot4(cur_key[3:0]);
    assign is_letter = key_base(code) != 8'd0;
    assign tap_max   = (key_q == 4'd8 || key_q == 4'd10) ? 2'd3 : 2'd2;
    assign cand      = key_base(key_q) + {6'd0, tap_q};
    assign last      = CW'(rd_q) == count_q - CW'(1);

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        tap_d          = tap_q;
        tmo_d          = (state_q == S_TAP) ? tmo_q + TW'(1) : '0;
        count_d        = count_q;
        rd_d           = rd_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        overflow_d     = 1'b0;
        game_end_d     = 1'b0;
        commit         = 1'b0;
        wr_en          = 1'b0;
        if (key_ok && code == K_END) begin
            game_end_d = 1'b1;
            state_d    = S_IDLE;
            count_d    = '0;
            rd_d       = '0;
            tmo_d      = '0;
        end else if (state_q == S_DRAIN) begin
            if (word_ready) begin
                rd_d    = last ? '0 : rd_q + AW'(1);
                count_d = last ? '0 : count_q;
                state_d = last ? S_IDLE : S_DRAIN;
            end
        end else if (key_ok && is_letter) begin
            // A new key in TAP commits the old candidate and starts the new one
            if (state_q == S_TAP && code == key_q) begin
                tap_d = (tap_q == tap_max) ? 2'd0 : tap_q + 2'd1;
            end else begin
                commit  = state_q == S_TAP;
                state_d = S_TAP;
                key_d   = code;
                tap_d   = 2'd0;
            end
            tmo_d = '0;
        end else if (key_ok && code == K_SUBL) begin
            commit  = state_q == S_TAP;
            state_d = S_IDLE;
        end else if (key_ok && code == K_CLR) begin
            if (state_q == S_TAP)
                state_d = S_IDLE;
            else if (count_q != '0)
                count_d = count_q - CW'(1);
        end else if (key_ok && code == K_SUBW) begin
            commit  = state_q == S_TAP;
            state_d = (state_q == S_TAP || count_q != '0) ? S_DRAIN : S_IDLE;
            rd_d    = '0;
        end else if (state_q == S_TAP && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            commit  = 1'b1;
            state_d = S_IDLE;
        end
        if (commit) begin
            wr_en          = count_q < CW'(WORD_DEPTH);
            overflow_d     = !wr_en;
            letter_valid_d = wr_en;
            letter_d       = wr_en ? cand : letter_q;
            count_d        = wr_en ? count_q + CW'(1) : count_q;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= S_IDLE;
            key_q          <= '0;
            tap_q          <= '0;
            tmo_q          <= '0;
            count_q        <= '0;
            rd_q           <= '0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            game_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            tap_q          <= tap_d;
            tmo_q          <= tmo_d;
            count_q        <= count_d;
            rd_q           <= rd_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            overflow_q     <= overflow_d;
            game_end_q     <= game_end_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[AW-1:0]] <= cand;
    end

    assign pending      = (state_q == S_TAP) ? cand : 8'd0;
    assign letter_valid = letter_valid_q;
    assign letter       = letter_q;
    assign overflow     = overflow_q;
    assign count        = count_q;
    assign word_valid   = state_q == S_DRAIN;
    assign word_data    = word_valid ? mem_q[rd_q] : 8'd0;
    assign word_last    = word_valid && last;
    assign game_end     = game_end_q;
endmodule

// File: tb/tb_multitap_word_entry.sv
// tb_multitap_word_entry: directed checks of multi-tap entry, commit, clear,
// overflow, timeout, word drain with back-pressure and game-end abort.
module tb_multitap_word_entry;
    localparam int TO = 6;
    localparam int WD = 4;
    localparam int CW = $clog2(WD + 1);

    logic          clk = 1'b0, nRst = 1'b0, strobe = 1'b0, word_ready = 1'b0;
    logic [7:0]    cur_key = 8'd0;
    logic [7:0]    pending, letter, word_data;
    logic          letter_valid, overflow, word_valid, word_last, game_end;
    logic [CW-1:0] count;
    int            n_chk = 0, n_err = 0;

    multitap_word_entry #(.TIMEOUT_CYCLES(TO), .WORD_DEPTH(WD)) dut (
        .clk(clk), .nRst(nRst), .strobe(strobe), .cur_key(cur_key),
        .pending(pending), .letter_valid(letter_valid), .letter(letter),
        .overflow(overflow), .count(count), .word_valid(word_valid),
        .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
        .game_end(game_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge clk);
        strobe  = 1'b1;
        cur_key = k;
        @(negedge clk);
        strobe  = 1'b0;
        cur_key = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [7:0] ABC = 8'h84, DEF = 8'h82, GHI = 8'h48, JKL = 8'h44;
    localparam logic [7:0] PQRS = 8'h28, TUV = 8'h24, WXYZ = 8'h22;
    localparam logic [7:0] SUBL = 8'h18, CLR = 8'h14, SUBW = 8'h12, GEND = 8'h21;

    initial begin
        idle(2);
        chk("rst_pending", pending, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_wvalid", word_valid, 0);
        chk("rst_letter", letter, 8'h00);
        chk("rst_pulses", {letter_valid, overflow, game_end}, 0);
        nRst = 1'b1;
        idle(1);

        press(8'hC4);
        chk("multihot_ignored", pending, 8'h00);
        press(8'h88);
        chk("r0c0_ignored", pending, 8'h00);
        press(SUBW);
        chk("subw_empty", word_valid, 0);

        press(PQRS); chk("tap_P", pending, "P");
        press(PQRS); chk("tap_Q", pending, "Q");
        press(PQRS); chk("tap_R", pending, "R");
        press(SUBL);
        chk("subl_valid", letter_valid, 1);
        chk("subl_letter", letter, "R");
        chk("subl_count", count, 1);
        chk("subl_pending", pending, 8'h00);
        idle(1);
        chk("valid_pulse_end", letter_valid, 0);
        press(CLR);
        chk("clr_idle", count, 0);

        press(ABC); press(ABC);
        chk("tap_B", pending, "B");
        idle(TO - 1);
        chk("pre_timeout_pend", pending, "B");
        chk("pre_timeout_valid", letter_valid, 0);
        idle(1);
        chk("timeout_valid", letter_valid, 1);
        chk("timeout_letter", letter, "B");
        chk("timeout_pending", pending, 8'h00);
        press(ABC);
        press(DEF);
        chk("newkey_valid", letter_valid, 1);
        chk("newkey_letter", letter, "A");
        chk("newkey_pending", pending, "D");
        chk("newkey_count", count, 2);
        press(SUBL);
        chk("commit_D", letter, "D");
        repeat (5) press(WXYZ);
        chk("wrap_W", pending, "W");
        press(SUBL);
        chk("full_count", count, WD);
        press(JKL);
        press(SUBL);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_no_valid", letter_valid, 0);
        chk("ovf_count", count, WD);
        chk("ovf_letter_held", letter, "W");
        idle(1);
        chk("ovf_pulse_end", overflow, 0);
        press(GEND);
        chk("gend_idle_pulse", game_end, 1);
        chk("gend_idle_count", count, 0);

        repeat (3) press(ABC);
        press(SUBL);
        press(ABC);
        press(SUBL);
        press(TUV);
        press(SUBW);
        chk("subw_commit_T", letter, "T");
        chk("subw_count", count, 3);
        chk("drain_valid", word_valid, 1);
        chk("drain_C", word_data, "C");
        chk("drain_last0", word_last, 0);
        chk("drain_pending", pending, 8'h00);
        press(GHI);
        chk("drain_key_ignored", pending, 8'h00);
        chk("stall_C", word_data, "C");
        chk("stall_valid", word_valid, 1);
        word_ready = 1'b1;
        idle(1);
        chk("drain_A", word_data, "A");
        word_ready = 1'b0;
        idle(1);
        chk("stall_A", word_data, "A");
        chk("stall_A_valid", word_valid, 1);
        word_ready = 1'b1;
        idle(1);
        chk("drain_T", word_data, "T");
        chk("drain_lastT", word_last, 1);
        idle(1);
        word_ready = 1'b0;
        chk("drain_done_valid", word_valid, 0);
        chk("drain_done_count", count, 0);

        press(GHI); press(GHI);
        press(SUBL);
        repeat (3) press(GHI);
        press(SUBL);
        chk("HI_count", count, 2);
        chk("HI_letter", letter, "I");
        press(CLR);
        chk("clr_newest", count, 1);
        press(GHI);
        chk("tap_G", pending, "G");
        press(CLR);
        chk("clr_tap_pending", pending, 8'h00);
        chk("clr_tap_count", count, 1);

        press(DEF);
        press(SUBW);
        chk("drain2_H", word_data, "H");
        chk("drain2_count", count, 2);
        press(GEND);
        chk("abort_pulse", game_end, 1);
        chk("abort_wvalid", word_valid, 0);
        chk("abort_count", count, 0);
        chk("abort_pending", pending, 8'h00);
        press(ABC);
        chk("abort_idle_tap", pending, "A");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/multitap_word_entry.md
MULTITAP_WORD_ENTRY -- requirements
Module: multitap_word_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 12000000, idle cycles after the last tap before the pending letter auto-commits (>=2).
REQ-002 Parameter WORD_DEPTH, default 8, letter buffer capacity (>=2); CW = $clog2(WORD_DEPTH+1).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 nRst  in  1  asynchronous active-low reset.
REQ-005 strobe  in  1  one-cycle pulse marking a new key press.
REQ-006 cur_key  in  8  {row[3:0], col[3:0]}, one-hot each, bit 7 = row 0, bit 3 = col 0.
REQ-007 pending  out  8  ASCII of candidate letter; 0 when none.
REQ-008 letter_valid  out  1  one-cycle pulse: letter written to buffer.
REQ-009 letter  out  8  ASCII of last committed letter, held until next commit.
REQ-010 overflow  out  1  one-cycle pulse: commit dropped, buffer full.
REQ-011 count  out  CW  letters currently buffered.
REQ-012 word_valid  out  1  word stream data valid.
REQ-013 word_data  out  8  word stream letter, oldest first.
REQ-014 word_last  out  1  high with final letter of word.
REQ-015 word_ready  in  1  downstream accept.
REQ-016 game_end  out  1  one-cycle pulse on game-end key.

Function
REQ-017 A strobe SHALL be ignored unless row and col are each exactly one-hot.
REQ-018 Letter keys: R0C1 ABC, R0C2 DEF, R1C0 GHI, R1C1 JKL, R1C2 MNO, R2C0 PQRS, R2C1 TUV, R2C2 WXYZ; letter = base + tap index.
REQ-019 Control keys: R3C0 submit-letter, R3C1 clear, R3C2 submit-word, R2C3 game-end; R0C0, R0C3, R1C3, R3C3 ignored.
REQ-020 States: IDLE (no candidate), TAP (candidate pending), DRAIN (word streaming); reset state IDLE.
REQ-021 IDLE + letter key: enter TAP, tap index 0, pending = base letter on next cycle.
REQ-022 TAP + same letter key: tap index +1, wrapping to 0 after 3 (3-letter keys) or 4 (PQRS, WXYZ); timeout counter cleared.
REQ-023 TAP + different letter key: commit candidate, start new candidate at index 0 of new key, same cycle.
REQ-024 TAP timeout counter increments each cycle without a tap; at TIMEOUT_CYCLES-1 commit and go IDLE.
REQ-025 Submit-letter: in TAP commit and go IDLE; in IDLE ignored.
REQ-026 Commit: if count<WORD_DEPTH write letter, count+1, letter_valid pulse; else drop and pulse overflow; both pulses registered one cycle after the triggering edge.
REQ-027 Clear: in TAP discard candidate, go IDLE; in IDLE with count>0 remove newest letter (count-1); count 0 ignored.
REQ-028 Submit-word: in TAP commit first (REQ-026), then DRAIN if resulting count>0; in IDLE DRAIN if count>0, else ignored.
REQ-029 DRAIN: word_valid=1, word_data=oldest unsent letter, word_last on final; advance only when word_valid&word_ready.
REQ-030 After last transfer: count=0, go IDLE next cycle; pending=0 throughout DRAIN.
REQ-031 All strobes in DRAIN ignored except game-end.
REQ-032 Game-end in any state: pulse game_end, discard candidate, count=0, abort drain, go IDLE.
REQ-033 word_valid SHALL not drop or word_data change while stalled (word_ready=0).

Reset
REQ-034 nRst low: state IDLE, all outputs 0, count 0, tap index and timeout counter 0, buffer pointers 0; in-flight word discarded, no pulses on release.

Verification
REQ-035 Press R2C0 three times, then submit-letter -> pending 'P','Q','R'; letter_valid, letter='R', count=1.
REQ-036 Press R0C1 twice, wait TIMEOUT_CYCLES -> auto-commit 'B'; press R0C1 then R0C2 -> 'A' committed, pending='D'.
REQ-037 Fill WORD_DEPTH letters, commit one more -> overflow pulse, count stays WORD_DEPTH.
REQ-038 Buffer "CAT", submit-word, word_ready toggling -> 'C','A','T' in order, word_last on 'T', data stable while stalled, count 0 after.
REQ-039 Buffer "HI", clear in IDLE -> count 1; tap R1C0, clear -> pending 0, count 1.
REQ-040 Game-end mid-DRAIN -> game_end pulse, word_valid 0 next cycle, count 0, IDLE.
